// File: rtl/ysyx_23060025_axi_xbar.sv
// rtl/ysyx_23060025_axi_xbar.sv - 1-to-2 AXI4 crossbar routing arbiter traffic to CLINT or SoC
module ysyx_23060025_axi_xbar #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter logic [ADDR_LEN-1:0] CLINT_BASE = 32'h0200_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_LEN-1:0]   up_araddr,
    input  logic                  up_arvalid,
    input  logic [3:0]            up_arid,
    input  logic [7:0]            up_arlen,
    input  logic [2:0]            up_arsize,
    input  logic [1:0]            up_arburst,
    output logic                  up_arready,
    output logic [DATA_LEN-1:0]   up_rdata,
    output logic [1:0]            up_rresp,
    output logic                  up_rvalid,
    output logic                  up_rlast,
    output logic [3:0]            up_rid,
    input  logic                  up_rready,
    input  logic [ADDR_LEN-1:0]   up_awaddr,
    input  logic                  up_awvalid,
    input  logic [3:0]            up_awid,
    input  logic [7:0]            up_awlen,
    input  logic [2:0]            up_awsize,
    input  logic [1:0]            up_awburst,
    output logic                  up_awready,
    input  logic [DATA_LEN-1:0]   up_wdata,
    input  logic [DATA_LEN/8-1:0] up_wstrb,
    input  logic                  up_wvalid,
    input  logic                  up_wlast,
    output logic                  up_wready,
    output logic [1:0]            up_bresp,
    output logic                  up_bvalid,
    output logic [3:0]            up_bid,
    input  logic                  up_bready,
    output logic [ADDR_LEN-1:0]   clint_araddr,
    output logic                  clint_arvalid,
    output logic [3:0]            clint_arid,
    output logic [7:0]            clint_arlen,
    output logic [2:0]            clint_arsize,
    output logic [1:0]            clint_arburst,
    input  logic                  clint_arready,
    input  logic [DATA_LEN-1:0]   clint_rdata,
    input  logic [1:0]            clint_rresp,
    input  logic                  clint_rvalid,
    input  logic                  clint_rlast,
    input  logic [3:0]            clint_rid,
    output logic                  clint_rready,
    output logic [ADDR_LEN-1:0]   soc_araddr,
    output logic                  soc_arvalid,
    output logic [3:0]            soc_arid,
    output logic [7:0]            soc_arlen,
    output logic [2:0]            soc_arsize,
    output logic [1:0]            soc_arburst,
    input  logic                  soc_arready,
    input  logic [DATA_LEN-1:0]   soc_rdata,
    input  logic [1:0]            soc_rresp,
    input  logic                  soc_rvalid,
    input  logic                  soc_rlast,
    input  logic [3:0]            soc_rid,
    output logic                  soc_rready,
    output logic [ADDR_LEN-1:0]   soc_awaddr,
    output logic                  soc_awvalid,
    output logic [3:0]            soc_awid,
    output logic [7:0]            soc_awlen,
    output logic [2:0]            soc_awsize,
    output logic [1:0]            soc_awburst,
    input  logic                  soc_awready,
    output logic [DATA_LEN-1:0]   soc_wdata,
    output logic [DATA_LEN/8-1:0] soc_wstrb,
    output logic                  soc_wvalid,
    output logic                  soc_wlast,
    input  logic                  soc_wready,
    input  logic [1:0]            soc_bresp,
    input  logic                  soc_bvalid,
    input  logic [3:0]            soc_bid,
    output logic                  soc_bready
);

    typedef enum logic [2:0] {IDLE, RD_CLINT, RD_SOC, WR_SOC, WR_ERR} state_t;

    localparam logic [ADDR_LEN-1:0] CLINT_MASK = 32'hffff_0000;

    state_t     state;
    logic       aw_done;
    logic       w_done;
    logic [3:0] lat_id;

    logic ar_hit, aw_hit, aw_hs, w_hs;

    assign ar_hit = (up_araddr & CLINT_MASK) == CLINT_BASE;
    assign aw_hit = (up_awaddr & CLINT_MASK) == CLINT_BASE;
    assign aw_hs  = up_awvalid && up_awready;
    assign w_hs   = up_wvalid && up_wready;

    // Routing is purely combinational; the FSM only decides which path is open.
    always_comb begin
        up_arready = 1'b0; up_awready = 1'b0; up_wready = 1'b0;
        up_rdata = '0; up_rresp = '0; up_rvalid = 1'b0; up_rlast = 1'b0; up_rid = '0;
        up_bresp = '0; up_bvalid = 1'b0; up_bid = '0;
        clint_araddr = '0; clint_arvalid = 1'b0; clint_arid = '0;
        clint_arlen = '0; clint_arsize = '0; clint_arburst = '0; clint_rready = 1'b0;
        soc_araddr = '0; soc_arvalid = 1'b0; soc_arid = '0;
        soc_arlen = '0; soc_arsize = '0; soc_arburst = '0; soc_rready = 1'b0;
        soc_awaddr = '0; soc_awvalid = 1'b0; soc_awid = '0;
        soc_awlen = '0; soc_awsize = '0; soc_awburst = '0;
        soc_wdata = '0; soc_wstrb = '0; soc_wvalid = 1'b0; soc_wlast = 1'b0;
        soc_bready = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (up_arvalid) begin
                        if (ar_hit) begin
                            clint_araddr = up_araddr; clint_arvalid = 1'b1; clint_arid = up_arid;
                            clint_arlen = up_arlen; clint_arsize = up_arsize; clint_arburst = up_arburst;
                            up_arready = clint_arready;
                        end else begin
                            soc_araddr = up_araddr; soc_arvalid = 1'b1; soc_arid = up_arid;
                            soc_arlen = up_arlen; soc_arsize = up_arsize; soc_arburst = up_arburst;
                            up_arready = soc_arready;
                        end
                    end else if (up_awvalid) begin
                        if (aw_hit) begin
                            up_awready = 1'b1;
                            up_wready  = 1'b1;
                        end else begin
                            soc_awaddr = up_awaddr; soc_awvalid = 1'b1; soc_awid = up_awid;
                            soc_awlen = up_awlen; soc_awsize = up_awsize; soc_awburst = up_awburst;
                            up_awready = soc_awready;
                            soc_wdata = up_wdata; soc_wstrb = up_wstrb; soc_wvalid = up_wvalid;
                            soc_wlast = up_wlast; up_wready = soc_wready;
                        end
                    end
                end
                RD_CLINT: begin
                    up_rdata = clint_rdata; up_rresp = clint_rresp; up_rvalid = clint_rvalid;
                    up_rlast = clint_rlast; up_rid = clint_rid; clint_rready = up_rready;
                end
                RD_SOC: begin
                    up_rdata = soc_rdata; up_rresp = soc_rresp; up_rvalid = soc_rvalid;
                    up_rlast = soc_rlast; up_rid = soc_rid; soc_rready = up_rready;
                end
                WR_SOC: begin
                    if (!aw_done) begin
                        soc_awaddr = up_awaddr; soc_awvalid = up_awvalid; soc_awid = up_awid;
                        soc_awlen = up_awlen; soc_awsize = up_awsize; soc_awburst = up_awburst;
                        up_awready = soc_awready;
                    end
                    if (!w_done) begin
                        soc_wdata = up_wdata; soc_wstrb = up_wstrb; soc_wvalid = up_wvalid;
                        soc_wlast = up_wlast; up_wready = soc_wready;
                    end
                    if (aw_done && w_done) begin
                        up_bresp = soc_bresp; up_bvalid = soc_bvalid; up_bid = soc_bid;
                        soc_bready = up_bready;
                    end
                end
                WR_ERR: begin
                    if (!w_done) begin
                        up_wready = 1'b1;
                    end else begin
                        up_bvalid = 1'b1;
                        up_bresp  = 2'b10;
                        up_bid    = lat_id;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            lat_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (up_arvalid) begin
                        if (up_arready) state <= ar_hit ? RD_CLINT : RD_SOC;
                    end else if (up_awvalid) begin
                        if (aw_hit) begin
                            lat_id <= up_awid;
                            w_done <= up_wvalid && up_wlast;
                            state  <= WR_ERR;
                        end else if (aw_hs || w_hs) begin
                            aw_done <= aw_hs;
                            w_done  <= w_hs && up_wlast;
                            state   <= WR_SOC;
                        end
                    end
                end
                RD_CLINT, RD_SOC: begin
                    if (up_rvalid && up_rready && up_rlast) state <= IDLE;
                end
                WR_SOC, WR_ERR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs && up_wlast) w_done <= 1'b1;
                    if (up_bvalid && up_bready) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_axi_xbar.sv
// tb/tb_ysyx_23060025_axi_xbar.sv - directed self-checking bench for the AXI crossbar
module tb_ysyx_23060025_axi_xbar;

    logic clock, reset;
    logic [31:0] up_araddr;  logic up_arvalid; logic [3:0] up_arid; logic [7:0] up_arlen;
    logic [2:0] up_arsize;   logic [1:0] up_arburst; logic up_arready;
    logic [31:0] up_rdata;   logic [1:0] up_rresp; logic up_rvalid, up_rlast; logic [3:0] up_rid;
    logic up_rready;
    logic [31:0] up_awaddr;  logic up_awvalid; logic [3:0] up_awid; logic [7:0] up_awlen;
    logic [2:0] up_awsize;   logic [1:0] up_awburst; logic up_awready;
    logic [31:0] up_wdata;   logic [3:0] up_wstrb; logic up_wvalid, up_wlast, up_wready;
    logic [1:0] up_bresp;    logic up_bvalid; logic [3:0] up_bid; logic up_bready;
    logic [31:0] clint_araddr; logic clint_arvalid; logic [3:0] clint_arid; logic [7:0] clint_arlen;
    logic [2:0] clint_arsize;  logic [1:0] clint_arburst; logic clint_arready;
    logic [31:0] clint_rdata;  logic [1:0] clint_rresp; logic clint_rvalid, clint_rlast;
    logic [3:0] clint_rid;     logic clint_rready;
    logic [31:0] soc_araddr; logic soc_arvalid; logic [3:0] soc_arid; logic [7:0] soc_arlen;
    logic [2:0] soc_arsize;  logic [1:0] soc_arburst; logic soc_arready;
    logic [31:0] soc_rdata;  logic [1:0] soc_rresp; logic soc_rvalid, soc_rlast;
    logic [3:0] soc_rid;     logic soc_rready;
    logic [31:0] soc_awaddr; logic soc_awvalid; logic [3:0] soc_awid; logic [7:0] soc_awlen;
    logic [2:0] soc_awsize;  logic [1:0] soc_awburst; logic soc_awready;
    logic [31:0] soc_wdata;  logic [3:0] soc_wstrb; logic soc_wvalid, soc_wlast, soc_wready;
    logic [1:0] soc_bresp;   logic soc_bvalid; logic [3:0] soc_bid; logic soc_bready;

    int n_assert = 0;
    int n_fail   = 0;

    ysyx_23060025_axi_xbar dut (
        .clock(clock), .reset(reset),
        .up_araddr(up_araddr), .up_arvalid(up_arvalid), .up_arid(up_arid), .up_arlen(up_arlen),
        .up_arsize(up_arsize), .up_arburst(up_arburst), .up_arready(up_arready),
        .up_rdata(up_rdata), .up_rresp(up_rresp), .up_rvalid(up_rvalid), .up_rlast(up_rlast),
        .up_rid(up_rid), .up_rready(up_rready),
        .up_awaddr(up_awaddr), .up_awvalid(up_awvalid), .up_awid(up_awid), .up_awlen(up_awlen),
        .up_awsize(up_awsize), .up_awburst(up_awburst), .up_awready(up_awready),
        .up_wdata(up_wdata), .up_wstrb(up_wstrb), .up_wvalid(up_wvalid), .up_wlast(up_wlast),
        .up_wready(up_wready),
        .up_bresp(up_bresp), .up_bvalid(up_bvalid), .up_bid(up_bid), .up_bready(up_bready),
        .clint_araddr(clint_araddr), .clint_arvalid(clint_arvalid), .clint_arid(clint_arid),
        .clint_arlen(clint_arlen), .clint_arsize(clint_arsize), .clint_arburst(clint_arburst),
        .clint_arready(clint_arready),
        .clint_rdata(clint_rdata), .clint_rresp(clint_rresp), .clint_rvalid(clint_rvalid),
        .clint_rlast(clint_rlast), .clint_rid(clint_rid), .clint_rready(clint_rready),
        .soc_araddr(soc_araddr), .soc_arvalid(soc_arvalid), .soc_arid(soc_arid),
        .soc_arlen(soc_arlen), .soc_arsize(soc_arsize), .soc_arburst(soc_arburst),
        .soc_arready(soc_arready),
        .soc_rdata(soc_rdata), .soc_rresp(soc_rresp), .soc_rvalid(soc_rvalid),
        .soc_rlast(soc_rlast), .soc_rid(soc_rid), .soc_rready(soc_rready),
        .soc_awaddr(soc_awaddr), .soc_awvalid(soc_awvalid), .soc_awid(soc_awid),
        .soc_awlen(soc_awlen), .soc_awsize(soc_awsize), .soc_awburst(soc_awburst),
        .soc_awready(soc_awready),
        .soc_wdata(soc_wdata), .soc_wstrb(soc_wstrb), .soc_wvalid(soc_wvalid),
        .soc_wlast(soc_wlast), .soc_wready(soc_wready),
        .soc_bresp(soc_bresp), .soc_bvalid(soc_bvalid), .soc_bid(soc_bid), .soc_bready(soc_bready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        up_araddr = '0; up_arvalid = 0; up_arid = '0; up_arlen = '0; up_arsize = 3'd2; up_arburst = 2'd1;
        up_rready = 0;
        up_awaddr = '0; up_awvalid = 0; up_awid = '0; up_awlen = '0; up_awsize = 3'd2; up_awburst = 2'd1;
        up_wdata = '0; up_wstrb = '0; up_wvalid = 0; up_wlast = 0; up_bready = 0;
        clint_arready = 0; clint_rdata = '0; clint_rresp = '0; clint_rvalid = 0; clint_rlast = 0;
        clint_rid = '0;
        soc_arready = 0; soc_rdata = '0; soc_rresp = '0; soc_rvalid = 0; soc_rlast = 0; soc_rid = '0;
        soc_awready = 0; soc_wready = 0; soc_bresp = '0; soc_bvalid = 0; soc_bid = '0;

        // Reset: valids/readies gated even with live requests
        tick();
        up_arvalid = 1; up_araddr = 32'h8000_0000; soc_arready = 1;
        #1;
        check("rst_up_arready", up_arready, 0);
        check("rst_soc_arvalid", soc_arvalid, 0);
        tick();
        up_arvalid = 0; soc_arready = 0; reset = 0;

        // T1: CLINT read
        up_araddr = 32'h0200_BFF8; up_arvalid = 1; up_arid = 4'd3; clint_arready = 1;
        #1;
        check("t1_clint_arvalid", clint_arvalid, 1);
        check("t1_clint_araddr", clint_araddr, 32'h0200_BFF8);
        check("t1_clint_arid", clint_arid, 3);
        check("t1_up_arready", up_arready, 1);
        check("t1_soc_arvalid", soc_arvalid, 0);
        check("t1_soc_araddr", soc_araddr, 0);
        tick();
        up_arvalid = 0; clint_arready = 0;
        clint_rvalid = 1; clint_rdata = 32'h1234_5678; clint_rresp = 0; clint_rlast = 1; clint_rid = 3;
        up_rready = 1;
        #1;
        check("t1_up_rvalid", up_rvalid, 1);
        check("t1_up_rdata", up_rdata, 32'h1234_5678);
        check("t1_up_rid", up_rid, 3);
        check("t1_clint_rready", clint_rready, 1);
        check("t1_soc_arvalid_rd", soc_arvalid, 0);
        tick();
        clint_rvalid = 0; up_rready = 0;

        // T2: SoC read with AR back-pressure and delayed R
        up_araddr = 32'h8000_0000; up_arvalid = 1; up_arid = 4'd5; soc_arready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_arready_stall", up_arready, 0);
            check("t2_soc_arvalid", soc_arvalid, 1);
            check("t2_clint_arvalid", clint_arvalid, 0);
            tick();
        end
        soc_arready = 1;
        #1;
        check("t2_arready_hs", up_arready, 1);
        check("t2_soc_araddr", soc_araddr, 32'h8000_0000);
        tick();
        up_araddr = 32'h8000_0004;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t2_block_arready", up_arready, 0);
            check("t2_block_soc_arvalid", soc_arvalid, 0);
            check("t2_rvalid_wait", up_rvalid, 0);
            tick();
        end
        soc_rvalid = 1; soc_rdata = 32'hCAFE_F00D; soc_rresp = 0; soc_rlast = 1; soc_rid = 5;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t2_rvalid_held", up_rvalid, 1);
            check("t2_rdata_held", up_rdata, 32'hCAFE_F00D);
            check("t2_soc_rready_lo", soc_rready, 0);
            tick();
        end
        up_arvalid = 0; up_rready = 1;
        #1;
        check("t2_soc_rready_hi", soc_rready, 1);
        check("t2_up_rid", up_rid, 5);
        tick();
        soc_rvalid = 0; up_rready = 0; soc_arready = 0;

        // T3: SoC write, AW at cycle 0, W at 2, B at 4
        up_awaddr = 32'hA000_0000; up_awid = 4'd7; up_awvalid = 1; soc_awready = 1; soc_wready = 1;
        #1;
        check("t3_soc_awvalid", soc_awvalid, 1);
        check("t3_soc_awaddr", soc_awaddr, 32'hA000_0000);
        check("t3_up_awready", up_awready, 1);
        check("t3_bvalid_c0", up_bvalid, 0);
        tick();
        up_awvalid = 0;
        #1;
        check("t3_soc_awvalid_c1", soc_awvalid, 0);
        check("t3_bvalid_c1", up_bvalid, 0);
        tick();
        up_wvalid = 1; up_wdata = 32'hDEAD_BEEF; up_wstrb = 4'hF; up_wlast = 1;
        #1;
        check("t3_soc_wvalid", soc_wvalid, 1);
        check("t3_soc_wdata", soc_wdata, 32'hDEAD_BEEF);
        check("t3_up_wready", up_wready, 1);
        tick();
        up_wvalid = 0; up_wlast = 0;
        #1;
        check("t3_bvalid_c3", up_bvalid, 0);
        tick();
        soc_bvalid = 1; soc_bresp = 0; soc_bid = 7; up_bready = 1;
        #1;
        check("t3_bvalid_c4", up_bvalid, 1);
        check("t3_bid", up_bid, 7);
        check("t3_soc_bready", soc_bready, 1);
        tick();
        soc_bvalid = 0; up_bready = 0;

        // T4: CLINT write terminated locally with SLVERR
        up_awaddr = 32'h0200_4000; up_awid = 4'd1; up_awvalid = 1;
        up_wvalid = 1; up_wdata = 32'h1111_2222; up_wlast = 1;
        #1;
        check("t4_awready", up_awready, 1);
        check("t4_wready", up_wready, 1);
        check("t4_soc_awvalid", soc_awvalid, 0);
        check("t4_soc_wvalid", soc_wvalid, 0);
        tick();
        up_awvalid = 0; up_wvalid = 0; up_wlast = 0;
        #1;
        check("t4_bvalid", up_bvalid, 1);
        check("t4_bresp", up_bresp, 2'b10);
        check("t4_bid", up_bid, 1);
        check("t4_soc_awvalid_b", soc_awvalid, 0);
        tick();
        #1;
        check("t4_bvalid_hold", up_bvalid, 1);
        up_bready = 1;
        tick();
        up_bready = 0;
        #1;
        check("t4_bvalid_done", up_bvalid, 0);

        // T5: simultaneous AR and AW; read first
        up_araddr = 32'h0200_0000; up_arvalid = 1; up_arid = 4'd2; clint_arready = 1;
        up_awaddr = 32'h8000_1000; up_awvalid = 1; up_awid = 4'd2;
        up_wvalid = 1; up_wdata = 32'h0BAD_F00D; up_wlast = 1;
        #1;
        check("t5_arready", up_arready, 1);
        check("t5_awready_blk", up_awready, 0);
        check("t5_soc_awvalid_blk", soc_awvalid, 0);
        tick();
        up_arvalid = 0; clint_arready = 0;
        clint_rvalid = 1; clint_rdata = 32'h0000_00AA; clint_rlast = 1; clint_rid = 2; up_rready = 1;
        #1;
        check("t5_rvalid", up_rvalid, 1);
        check("t5_awready_rd", up_awready, 0);
        tick();
        clint_rvalid = 0; up_rready = 0;
        #1;
        check("t5_awready_after", up_awready, 1);
        check("t5_soc_awvalid", soc_awvalid, 1);
        check("t5_soc_wvalid", soc_wvalid, 1);
        tick();
        up_awvalid = 0; up_wvalid = 0; up_wlast = 0;
        soc_bvalid = 1; soc_bid = 2; up_bready = 1;
        #1;
        check("t5_bvalid", up_bvalid, 1);
        check("t5_bid", up_bid, 2);
        tick();
        soc_bvalid = 0; up_bready = 0; soc_awready = 0; soc_wready = 0;

        // T6: reset right after an SoC AR handshake, then a clean CLINT read
        up_araddr = 32'h8000_0008; up_arvalid = 1; soc_arready = 1;
        #1;
        check("t6_arready", up_arready, 1);
        tick();
        up_arvalid = 0; soc_arready = 0;
        reset = 1; soc_rvalid = 1; soc_rdata = 32'hFFFF_0000; soc_rlast = 1; up_rready = 1;
        #1;
        check("t6_rst_rvalid", up_rvalid, 0);
        check("t6_rst_soc_rready", soc_rready, 0);
        tick();
        reset = 0;
        #1;
        check("t6_post_rvalid", up_rvalid, 0);
        soc_rvalid = 0;
        up_araddr = 32'h0200_0010; up_arvalid = 1; clint_arready = 1;
        #1;
        check("t6_clint_arvalid", clint_arvalid, 1);
        check("t6_soc_arvalid", soc_arvalid, 0);
        check("t6_up_arready", up_arready, 1);
        tick();
        up_arvalid = 0; clint_arready = 0;
        clint_rvalid = 1; clint_rdata = 32'h55AA_55AA; clint_rlast = 1; clint_rid = 0;
        #1;
        check("t6_rvalid", up_rvalid, 1);
        check("t6_rdata", up_rdata, 32'h55AA_55AA);
        check("t6_soc_rready", soc_rready, 0);
        tick();
        clint_rvalid = 0; up_rready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
